// File: rtl/shift_issue_stage_if.sv
// Request/result bundle for shift_issue_stage: producer handshake, the
// drive/return path to the external combinational funnel shifter, and the
// consumer handshake with the FIFO occupancy.
interface shift_issue_stage_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          inValid;
  logic          inReady;
  logic [7:0]    inData;
  logic [2:0]    inK;
  logic          inLeft;

  logic [7:0]    shDataIn;
  logic [2:0]    shK;
  logic          shLeft;
  logic [7:0]    shDataOut;

  logic          outValid;
  logic          outReady;
  logic [7:0]    outData;
  logic          outLeft;
  logic [CW-1:0] count;

  // Stage side: accepts requests, drives the shifter, presents results.
  modport slave (
    input  inValid, inData, inK, inLeft, shDataOut, outReady,
    output inReady, shDataIn, shK, shLeft, outValid, outData, outLeft, count
  );

  // Environment side: producer, shifter and consumer.
  modport master (
    output inValid, inData, inK, inLeft, shDataOut, outReady,
    input  inReady, shDataIn, shK, shLeft, outValid, outData, outLeft, count
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Issue/capture stage around an 8-bit combinational funnel shifter.
// Requests queue in a small circular FIFO; the head entry drives the shifter
// and its result is captured into a holding register with its own handshake.
module shift_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_issue_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_memData [DEPTH];
  logic [2:0]    r_memK    [DEPTH];
  logic          r_memLeft [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_outValid;
  logic [7:0]    r_outData;
  logic          r_outLeft;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.inValid & ~w_full;
  assign w_pop   = ~w_empty & (~r_outValid | bus.outReady);

  assign bus.inReady  = ~w_full;
  assign bus.shDataIn = r_memData[r_rdPtr];
  assign bus.shK      = r_memK[r_rdPtr];
  assign bus.shLeft   = r_memLeft[r_rdPtr];
  assign bus.outValid = r_outValid;
  assign bus.outData  = r_outData;
  assign bus.outLeft  = r_outLeft;
  assign bus.count    = r_count;

  // Request storage: write the tail slot on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_memData[i] <= '0;
        r_memK[i]    <= '0;
        r_memLeft[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_memData[r_wrPtr] <= bus.inData;
      r_memK[r_wrPtr]    <= bus.inK;
      r_memLeft[r_wrPtr] <= bus.inLeft;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result holding register: capture on pop, clear valid when drained, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLeft  <= 1'b0;
    end else if (w_pop) begin
      r_outValid <= 1'b1;
      r_outData  <= bus.shDataOut;
      r_outLeft  <= r_memLeft[r_rdPtr];
    end else if (r_outValid & bus.outReady) begin
      r_outValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a behavioural shifter attached
// to the sh* path and a small ordering scoreboard for streaming scenarios.
module tb_shift_issue_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  shift_issue_stage_if #(.DEPTH(4)) bus ();

  shift_issue_stage #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural zero-latency logical shifter.
  assign bus.shDataOut = bus.shLeft ? (bus.shDataIn << bus.shK) : (bus.shDataIn >> bus.shK);

  // Free-running clock.
  always #5 clk = ~clk;

  // Bit-serial reference shift for scoreboard entries.
  function automatic logic [7:0] refShift(input logic [7:0] d, input logic [2:0] k, input logic l);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < int'(k); i++) r = l ? {r[6:0], 1'b0} : {1'b0, r[7:1]};
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] k, input logic l);
    bus.inValid = v;
    bus.inData  = d;
    bus.inK     = k;
    bus.inLeft  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    bus.outReady = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid got %0b exp 0", bus.outValid); end
    checks++; if (bus.outData !== 8'h00) begin errors++; $display("[TB] FAIL reset_outData got %h exp 00", bus.outData); end
    checks++; if (bus.outLeft !== 1'b0) begin errors++; $display("[TB] FAIL reset_outLeft got %0b exp 0", bus.outLeft); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_inReady got %0b exp 1", bus.inReady); end
    checks++; if (bus.shDataIn !== 8'h00) begin errors++; $display("[TB] FAIL reset_shDataIn got %h exp 00", bus.shDataIn); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] vData [6] = '{8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hFF, 8'hFF};
    logic [2:0] vK    [6] = '{3'd3,  3'd3,  3'd0,  3'd0,  3'd7,  3'd7};
    logic       vLeft [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] vExp  [6] = '{8'hA8, 8'h16, 8'hB5, 8'hB5, 8'h80, 8'h01};
    bus.outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vData[i], vK[i], vLeft[i]);
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      checks++; if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL dir%0d_count_queued got %0d exp 1", i, bus.count); end
      checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_early_valid got %0b exp 0", i, bus.outValid); end
      @(negedge clk);
      checks++; if (bus.outValid !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_valid got %0b exp 1", i, bus.outValid); end
      checks++; if (bus.outData !== vExp[i]) begin errors++; $display("[TB] FAIL dir%0d_data got %h exp %h", i, bus.outData, vExp[i]); end
      checks++; if (bus.outLeft !== vLeft[i]) begin errors++; $display("[TB] FAIL dir%0d_left got %0b exp %0b", i, bus.outLeft, vLeft[i]); end
      @(negedge clk);
      checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_drain got %0b exp 0", i, bus.outValid); end
    end
  endtask

  task automatic test_stall_fill();
    logic [7:0] vData [5] = '{8'h81, 8'h81, 8'h3C, 8'h3C, 8'h96};
    logic [2:0] vK    [5] = '{3'd1,  3'd1,  3'd2,  3'd2,  3'd4};
    logic       vLeft [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] vExp  [5] = '{8'h02, 8'h40, 8'hF0, 8'h0F, 8'h60};
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL fill%0d_inReady got %0b exp 1", i, bus.inReady); end
      applyStimulus(1'b1, vData[i], vK[i], vLeft[i]);
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count got %0d exp 4", bus.count); end
    checks++; if (bus.inReady !== 1'b0) begin errors++; $display("[TB] FAIL fill_inReady_full got %0b exp 0", bus.inReady); end
    repeat (3) @(negedge clk);
    checks++; if (bus.outValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid got %0b exp 1", bus.outValid); end
    checks++; if (bus.outData !== vExp[0]) begin errors++; $display("[TB] FAIL stall_data got %h exp %h", bus.outData, vExp[0]); end
    bus.outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.outValid !== 1'b1) begin errors++; $display("[TB] FAIL drain%0d_valid got %0b exp 1", i, bus.outValid); end
      checks++; if (bus.outData !== vExp[i]) begin errors++; $display("[TB] FAIL drain%0d_data got %h exp %h", i, bus.outData, vExp[i]); end
      checks++; if (bus.outLeft !== vLeft[i]) begin errors++; $display("[TB] FAIL drain%0d_left got %0b exp %0b", i, bus.outLeft, vLeft[i]); end
      checks++; if (int'(bus.count) !== 4 - i) begin errors++; $display("[TB] FAIL drain%0d_count got %0d exp %0d", i, bus.count, 4 - i); end
      @(negedge clk);
    end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_valid got %0b exp 0", bus.outValid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL drain_end_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] expQ [$];
    logic [8:0] e;
    logic [7:0] d;
    logic [2:0] k;
    logic       l;
    int         sent = 0;
    int         got = 0;
    bus.outReady = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
      if (bus.outValid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra got %h exp none", bus.outData);
        end else begin
          e = expQ.pop_front();
          if ({bus.outLeft, bus.outData} !== e) begin
            errors++; $display("[TB] FAIL b2b_result%0d got %h exp %h", got, {bus.outLeft, bus.outData}, e);
          end
        end
        got++;
      end
      checks++; if (int'(bus.count) > 1) begin errors++; $display("[TB] FAIL b2b_count got %0d exp <=1", bus.count); end
      if (sent < 20) begin
        d = 8'(sent * 37 + 11);
        k = 3'(sent);
        l = sent[0];
        applyStimulus(1'b1, d, k, l);
        if (bus.inReady === 1'b1) begin
          expQ.push_back({l, refShift(d, k, l)});
          sent++;
        end
      end else begin
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    checks++; if (got !== 20) begin errors++; $display("[TB] FAIL b2b_total got %0d exp 20", got); end
  endtask

  task automatic test_random_stall();
    logic [8:0] expQ [$];
    logic [8:0] e;
    logic [7:0] d;
    logic [2:0] k;
    logic       l;
    logic       pending = 1'b0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    int         sent = 0;
    int         got = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      if (prevStall) begin
        checks++;
        if (bus.outValid !== 1'b1 || bus.outData !== prevData) begin
          errors++; $display("[TB] FAIL rnd_stall_hold got %0b/%h exp 1/%h", bus.outValid, bus.outData, prevData);
        end
      end
      bus.outReady = 1'($urandom_range(0, 1));
      if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_extra got %h exp none", bus.outData);
        end else begin
          e = expQ.pop_front();
          if ({bus.outLeft, bus.outData} !== e) begin
            errors++; $display("[TB] FAIL rnd_result%0d got %h exp %h", got, {bus.outLeft, bus.outData}, e);
          end
        end
        got++;
      end
      prevStall = (bus.outValid === 1'b1) && (bus.outReady === 1'b0);
      prevData  = bus.outData;
      if (!pending) begin
        if (sent < 16 && $urandom_range(0, 3) != 0) begin
          d = 8'(sent * 53 + 7);
          k = 3'(sent + 2);
          l = ~sent[1];
          applyStimulus(1'b1, d, k, l);
          pending = 1'b1;
        end else begin
          applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
        end
      end
      if (pending && bus.inReady === 1'b1) begin
        expQ.push_back({l, refShift(d, k, l)});
        sent++;
        pending = 1'b0;
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    bus.outReady = 1'b1;
    checks++; if (got !== 16) begin errors++; $display("[TB] FAIL rnd_total got %0d exp 16", got); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL rnd_leftover got %0d exp 0", expQ.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h11 + 8'(i), 3'd1, 1'b1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("[TB] FAIL ares_pre_count got %0d exp 3", bus.count); end
    checks++; if (bus.outValid !== 1'b1 || bus.outData !== 8'h22) begin errors++; $display("[TB] FAIL ares_pre_out got %0b/%h exp 1/22", bus.outValid, bus.outData); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL ares_outValid got %0b exp 0", bus.outValid); end
    checks++; if (bus.outData !== 8'h00) begin errors++; $display("[TB] FAIL ares_outData got %h exp 00", bus.outData); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL ares_count got %0d exp 0", bus.count); end
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL ares_inReady got %0b exp 1", bus.inReady); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.outReady = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'h5A, 3'd2, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL post_count got %0d exp 1", bus.count); end
    @(negedge clk);
    checks++; if (bus.outValid !== 1'b1 || bus.outData !== 8'h16 || bus.outLeft !== 1'b0) begin
      errors++; $display("[TB] FAIL post_result got %0b/%h/%0b exp 1/16/0", bus.outValid, bus.outData, bus.outLeft);
    end
    @(negedge clk);
    checks++; if (bus.outValid !== 1'b0 || bus.count !== 3'd0) begin
      errors++; $display("[TB] FAIL post_no_stale got %0b/%0d exp 0/0", bus.outValid, bus.count);
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_directed();
    test_stall_fill();
    test_back_to_back();
    test_random_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a hung handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got running exp finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
